// File: rtl/arm_ldm_stm_seq_if.sv
// rtl/arm_ldm_stm_seq_if.sv - instruction, micro-op and writeback bundle for the LDM/STM sequencer
// Ports (slave = sequencer view):
//   in : flush, inst_valid, inst, cond_pass, rn_value, uop_ready
//   out: inst_ready, uop_valid, uop_load, uop_reg, uop_addr, uop_last,
//        wb_we, wb_reg, wb_value, busy
interface arm_ldm_stm_seq_if #(
  parameter int REG_IDX_W = 4,
  parameter int ADDR_W    = 32
);
  logic                 flush;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [31:0]          inst;
  logic                 cond_pass;
  logic [ADDR_W-1:0]    rn_value;
  logic                 uop_valid;
  logic                 uop_ready;
  logic                 uop_load;
  logic [REG_IDX_W-1:0] uop_reg;
  logic [ADDR_W-1:0]    uop_addr;
  logic                 uop_last;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_reg;
  logic [ADDR_W-1:0]    wb_value;
  logic                 busy;

  modport master (
    output flush, inst_valid, inst, cond_pass, rn_value, uop_ready,
    input  inst_ready, uop_valid, uop_load, uop_reg, uop_addr, uop_last,
           wb_we, wb_reg, wb_value, busy
  );

  modport slave (
    input  flush, inst_valid, inst, cond_pass, rn_value, uop_ready,
    output inst_ready, uop_valid, uop_load, uop_reg, uop_addr, uop_last,
           wb_we, wb_reg, wb_value, busy
  );
endinterface

// File: rtl/arm_ldm_stm_seq.sv
// rtl/arm_ldm_stm_seq.sv - expands ARM LDM/STM into per-register micro-ops plus base writeback
// Ports:
//   clk   in  clock, rising edge
//   reset in  synchronous active-high reset
//   bus   slave modport of arm_ldm_stm_seq_if (instruction in, micro-ops and writeback out)
module arm_ldm_stm_seq #(
  parameter int REG_COUNT  = 16,
  parameter int REG_IDX_W  = 4,
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  arm_ldm_stm_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  state_t               state, state_nxt;
  logic [REG_COUNT-1:0] list_r;
  logic                 load_r;
  logic                 wb_en_r;
  logic [REG_IDX_W-1:0] rn_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [ADDR_W-1:0]    wb_value_r;

  function automatic logic [REG_IDX_W:0] popcount(input logic [REG_COUNT-1:0] v);
    logic [REG_IDX_W:0] c;
    c = '0;
    for (int i = 0; i < REG_COUNT; i++) c = c + {{REG_IDX_W{1'b0}}, v[i]};
    return c;
  endfunction

  function automatic logic [REG_IDX_W-1:0] lowest(input logic [REG_COUNT-1:0] v);
    logic [REG_IDX_W-1:0] idx;
    idx = '0;
    for (int i = REG_COUNT - 1; i >= 0; i--) if (v[i]) idx = REG_IDX_W'(i);
    return idx;
  endfunction

  // Decode of the instruction presented at the input
  logic [REG_COUNT-1:0] inst_list;
  logic [REG_IDX_W-1:0] inst_rn;
  logic                 f_p, f_u, f_w, f_l;
  logic                 accept, start_seq;
  logic [ADDR_W-1:0]    span, start_addr;

  assign inst_list = bus.inst[REG_COUNT-1:0];
  assign inst_rn   = REG_IDX_W'(bus.inst[19:16]);
  assign f_p       = bus.inst[24];
  assign f_u       = bus.inst[23];
  assign f_w       = bus.inst[21];
  assign f_l       = bus.inst[20];
  assign accept    = bus.inst_valid && (state == IDLE) && !reset;
  // Failed condition, non-LDM/STM or empty list: consumed silently
  assign start_seq = accept && bus.cond_pass && (bus.inst[27:25] == 3'b100) && (|inst_list);
  assign span      = ADDR_W'(popcount(inst_list)) * STRIDE;

  // Transfers always run at ascending addresses; decrement modes start low
  always_comb begin
    start_addr = bus.rn_value;
    case ({f_p, f_u})
      2'b01:   start_addr = bus.rn_value;
      2'b11:   start_addr = bus.rn_value + STRIDE;
      2'b00:   start_addr = bus.rn_value - span + STRIDE;
      default: start_addr = bus.rn_value - span;
    endcase
  end

  logic [REG_COUNT-1:0] list_rest;
  logic                 one_left;
  assign list_rest = list_r & (list_r - REG_COUNT'(1));   // clears lowest set bit
  assign one_left  = (list_r != '0) && (list_rest == '0);

  always_comb begin
    state_nxt      = state;
    bus.inst_ready = (state == IDLE) && !reset;
    bus.uop_valid  = (state == ISSUE);
    bus.uop_last   = (state == ISSUE) && one_left;
    bus.uop_load   = load_r;
    bus.uop_reg    = lowest(list_r);
    bus.uop_addr   = addr_r;
    bus.wb_we      = (state == WB);
    bus.wb_reg     = rn_r;
    bus.wb_value   = wb_value_r;
    bus.busy       = (state != IDLE);
    case (state)
      IDLE:    if (start_seq) state_nxt = ISSUE;
      ISSUE:   if (bus.uop_ready && one_left) state_nxt = wb_en_r ? WB : IDLE;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      list_r     <= '0;
      load_r     <= 1'b0;
      wb_en_r    <= 1'b0;
      rn_r       <= '0;
      addr_r     <= '0;
      wb_value_r <= '0;
    end else begin
      state <= state_nxt;
      if (bus.flush) begin
        list_r <= '0;
      end else if (start_seq) begin
        list_r     <= inst_list;
        load_r     <= f_l;
        // A load that overwrites Rn makes the loaded value win over writeback
        wb_en_r    <= f_w && !(f_l && inst_list[inst_rn]);
        rn_r       <= inst_rn;
        addr_r     <= start_addr;
        wb_value_r <= f_u ? (bus.rn_value + span) : (bus.rn_value - span);
      end else if (state == ISSUE && bus.uop_ready) begin
        list_r <= list_rest;
        addr_r <= addr_r + STRIDE;
      end
    end
  end
endmodule

// File: tb/tb_arm_ldm_stm_seq.sv
// tb/tb_arm_ldm_stm_seq.sv - directed self-checking bench for arm_ldm_stm_seq
module tb_arm_ldm_stm_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  arm_ldm_stm_seq_if bus ();

  arm_ldm_stm_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] rn, input logic cp);
    chk({tag, ".inst_ready"}, 32'(bus.inst_ready), 32'd1);
    bus.inst       = ins;
    bus.rn_value   = rn;
    bus.cond_pass  = cp;
    bus.inst_valid = 1'b1;
    tick();
    bus.inst_valid = 1'b0;
  endtask

  task automatic exp_uop(input string tag, input logic [3:0] r, input logic [31:0] a,
                         input logic last, input logic ld);
    chk({tag, ".valid"}, 32'(bus.uop_valid), 32'd1);
    chk({tag, ".reg"},   32'(bus.uop_reg),   32'(r));
    chk({tag, ".addr"},  bus.uop_addr,       a);
    chk({tag, ".last"},  32'(bus.uop_last),  32'(last));
    chk({tag, ".load"},  32'(bus.uop_load),  32'(ld));
    chk({tag, ".wb_we"}, 32'(bus.wb_we),     32'd0);
  endtask

  task automatic exp_wb(input string tag, input logic [3:0] r, input logic [31:0] v);
    chk({tag, ".wb_we"},    32'(bus.wb_we),     32'd1);
    chk({tag, ".wb_reg"},   32'(bus.wb_reg),    32'(r));
    chk({tag, ".wb_value"}, bus.wb_value,       v);
    chk({tag, ".uop_valid"}, 32'(bus.uop_valid), 32'd0);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, ".uop_valid"},  32'(bus.uop_valid),  32'd0);
    chk({tag, ".wb_we"},      32'(bus.wb_we),      32'd0);
    chk({tag, ".busy"},       32'(bus.busy),       32'd0);
    chk({tag, ".inst_ready"}, 32'(bus.inst_ready), 32'd1);
  endtask

  initial begin
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.inst_valid = 1'b0;
    bus.inst       = 32'h0;
    bus.cond_pass  = 1'b1;
    bus.rn_value   = 32'h0;
    bus.uop_ready  = 1'b1;
    tick();
    tick();
    chk("rst.inst_ready", 32'(bus.inst_ready), 32'd0);
    chk("rst.uop_valid",  32'(bus.uop_valid),  32'd0);
    chk("rst.wb_we",      32'(bus.wb_we),      32'd0);
    chk("rst.uop_last",   32'(bus.uop_last),   32'd0);
    chk("rst.uop_load",   32'(bus.uop_load),   32'd0);
    chk("rst.uop_reg",    32'(bus.uop_reg),    32'd0);
    chk("rst.uop_addr",   bus.uop_addr,        32'd0);
    chk("rst.wb_reg",     32'(bus.wb_reg),     32'd0);
    chk("rst.wb_value",   bus.wb_value,        32'd0);
    reset = 1'b0;
    tick();
    exp_idle("rst.out");

    // LDMIA r0!,{r1,r2,r4}
    issue("ldmia", 32'hE8B00016, 32'h1000, 1'b1);
    exp_uop("ldmia.u0", 4'd1, 32'h1000, 1'b0, 1'b1); chk("ldmia.busy", 32'(bus.busy), 32'd1); tick();
    exp_uop("ldmia.u1", 4'd2, 32'h1004, 1'b0, 1'b1); tick();
    exp_uop("ldmia.u2", 4'd4, 32'h1008, 1'b1, 1'b1); tick();
    exp_wb("ldmia.wb", 4'd0, 32'h100C);
    chk("ldmia.wb_inst_ready", 32'(bus.inst_ready), 32'd0); tick();
    exp_idle("ldmia.end");

    // STMDB r13!,{r4-r7,r14}, accepted right after the previous sequence
    issue("stmdb", 32'hE92D40F0, 32'h2000, 1'b1);
    exp_uop("stmdb.u0", 4'd4,  32'h1FEC, 1'b0, 1'b0); tick();
    exp_uop("stmdb.u1", 4'd5,  32'h1FF0, 1'b0, 1'b0); tick();
    exp_uop("stmdb.u2", 4'd6,  32'h1FF4, 1'b0, 1'b0); tick();
    exp_uop("stmdb.u3", 4'd7,  32'h1FF8, 1'b0, 1'b0); tick();
    exp_uop("stmdb.u4", 4'd14, 32'h1FFC, 1'b1, 1'b0); tick();
    exp_wb("stmdb.wb", 4'd13, 32'h1FEC); tick();
    exp_idle("stmdb.end");

    // STMDA r5!,{r1,r2}, r5=0x100
    issue("stmda", 32'hE8250006, 32'h100, 1'b1);
    exp_uop("stmda.u0", 4'd1, 32'h0FC, 1'b0, 1'b0); tick();
    exp_uop("stmda.u1", 4'd2, 32'h100, 1'b1, 1'b0); tick();
    exp_wb("stmda.wb", 4'd5, 32'h0F8); tick();
    exp_idle("stmda.end");

    // Backpressure: STMIA r1,{r0,r3,r5}, stall 3 cycles on 2nd uop
    issue("bp", 32'hE8810029, 32'h300, 1'b1);
    exp_uop("bp.u0", 4'd0, 32'h300, 1'b0, 1'b0); tick();
    exp_uop("bp.u1", 4'd3, 32'h304, 1'b0, 1'b0);
    bus.uop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_uop($sformatf("bp.hold%0d", i), 4'd3, 32'h304, 1'b0, 1'b0);
    end
    bus.uop_ready = 1'b1;
    tick();
    exp_uop("bp.u2", 4'd5, 32'h308, 1'b1, 1'b0); tick();
    exp_idle("bp.end");

    // Consumed without effect: condition fail, ADD, empty list
    issue("cfail", 32'hE8B00016, 32'h1000, 1'b0);
    exp_idle("cfail.c1"); tick(); exp_idle("cfail.c2");
    issue("add", 32'hE0811002, 32'h1000, 1'b1);
    exp_idle("add.c1"); tick(); exp_idle("add.c2");
    issue("empty", 32'hE8B00000, 32'h1000, 1'b1);
    exp_idle("empty.c1"); tick(); exp_idle("empty.c2");

    // Flush during the first handshake of three
    issue("fl", 32'hE8B00016, 32'h1000, 1'b1);
    exp_uop("fl.u0", 4'd1, 32'h1000, 1'b0, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    exp_idle("fl.c1"); tick(); exp_idle("fl.c2"); tick(); exp_idle("fl.c3");

    // Reset after the first of three uops
    issue("rs", 32'hE8B00016, 32'h1000, 1'b1);
    exp_uop("rs.u0", 4'd1, 32'h1000, 1'b0, 1'b1); tick();
    reset = 1'b1;
    tick();
    chk("rs.uop_valid",  32'(bus.uop_valid),  32'd0);
    chk("rs.wb_we",      32'(bus.wb_we),      32'd0);
    chk("rs.busy",       32'(bus.busy),       32'd0);
    chk("rs.inst_ready", 32'(bus.inst_ready), 32'd0);
    chk("rs.uop_addr",   bus.uop_addr,        32'd0);
    chk("rs.wb_value",   bus.wb_value,        32'd0);
    reset = 1'b0;
    tick();
    exp_idle("rs.end");

    // LDMIB r3!,{r3,r5}: writeback suppressed since Rn is loaded
    issue("ldmib", 32'hE9B30028, 32'h40, 1'b1);
    exp_uop("ldmib.u0", 4'd3, 32'h44, 1'b0, 1'b1); tick();
    exp_uop("ldmib.u1", 4'd5, 32'h48, 1'b1, 1'b1); tick();
    exp_idle("ldmib.end"); tick(); exp_idle("ldmib.end2");

    // Address wrap: LDMIA r2,{r0,r1}, r2=0xFFFFFFFC
    issue("wrap", 32'hE8920003, 32'hFFFFFFFC, 1'b1);
    exp_uop("wrap.u0", 4'd0, 32'hFFFFFFFC, 1'b0, 1'b1); tick();
    exp_uop("wrap.u1", 4'd1, 32'h00000000, 1'b1, 1'b1); tick();
    exp_idle("wrap.end"); tick(); exp_idle("wrap.end2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
